// File: rtl/enc_pkg.sv
// Shared definitions for the N-to-log2(N) streaming encoder.
//   - mode selectors (STRICT one-hot, PRIO priority, SCAN serialise)
//   - controller state enum
//   - default error-counter width and its saturation value
package enc_pkg;

  localparam int ENC_STRICT = 0;
  localparam int ENC_PRIO   = 1;
  localparam int ENC_SCAN   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_t;

  localparam int                        ENC_CNT_W_DEF   = 8;
  localparam logic [ENC_CNT_W_DEF-1:0]  ENC_CNT_MAX_DEF = '1;

endpackage

// File: rtl/encoder_nx_stream_priority_pick.sv
// priority_pick: combinational first-set-bit finder.
//   vec    : input vector
//   idx    : index of the winning bit (highest if PRIO_MSB, else lowest); 0 if none
//   any    : at least one bit set
//   onehot : exactly one bit set
module priority_pick #(
  parameter  int N        = 8,
  parameter  bit PRIO_MSB = 1'b0,
  localparam int W        = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         onehot
);

  // The loop walks toward the preferred end so the last hit is the winner.
  always_comb begin
    idx = '0;
    if (PRIO_MSB) begin
      for (int i = 0; i < N; i++)
        if (vec[i]) idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (vec[i]) idx = W'(i);
    end
  end

  assign any    = |vec;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign onehot = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/encoder_nx_stream.sv
// encoder_nx_stream: N-input to log2(N)-bit encoder with valid/ready on both
// sides and a registered output beat.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake, in_data is the request vector
//   out_valid/out_ready: output handshake for out_code/out_err/out_last
//   err_clr / err_cnt  : clear and saturating count of transferred error beats
// MODE selects STRICT one-hot, PRIO priority, or SCAN (one beat per set bit).
module encoder_nx_stream
  import enc_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int MODE     = ENC_STRICT,
  parameter  int PRIO_MSB = 0,
  parameter  int CNT_W    = ENC_CNT_W_DEF,
  localparam int W        = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_err,
  output logic             out_last,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  enc_state_t       state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     code_q, code_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0] in_idx, pend_idx;
  logic         in_any, in_onehot, pend_any, pend_onehot;
  logic         in_xfer, out_xfer;

  priority_pick #(.N(N), .PRIO_MSB(PRIO_MSB != 0)) u_pick_in (
    .vec(in_data), .idx(in_idx), .any(in_any), .onehot(in_onehot)
  );

  priority_pick #(.N(N), .PRIO_MSB(PRIO_MSB != 0)) u_pick_pend (
    .vec(pend_q), .idx(pend_idx), .any(pend_any), .onehot(pend_onehot)
  );

  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    code_d      = code_q;
    err_d       = err_q;
    last_d      = last_q;

    if (out_xfer) out_valid_d = 1'b0;

    if (in_xfer) begin
      out_valid_d = 1'b1;
      // Anything that is not a clean hit reports code 0 with the error flag.
      code_d = '0;
      err_d  = 1'b1;
      last_d = 1'b1;
      case (MODE)
        ENC_STRICT: if (in_onehot) begin
          code_d = in_idx;
          err_d  = 1'b0;
        end
        ENC_PRIO: if (in_any) begin
          code_d = in_idx;
          err_d  = 1'b0;
        end
        ENC_SCAN: if (in_any) begin
          code_d = in_idx;
          err_d  = 1'b0;
          pend_d = in_data & ~(N'(1) << in_idx);
          last_d = in_onehot;
          if (!in_onehot) state_d = SCAN;
        end
        default: ;
      endcase
    end else if (state_q == SCAN && out_xfer && pend_any) begin
      // Next beat replaces the one just taken; the final beat returns to
      // IDLE right away so the next vector can be taken as it drains.
      out_valid_d = 1'b1;
      code_d      = pend_idx;
      err_d       = 1'b0;
      pend_d      = pend_q & ~(N'(1) << pend_idx);
      last_d      = pend_onehot;
      if (pend_onehot) state_d = IDLE;
    end
  end

  // Clear wins over a coinciding increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)                                  cnt_d = '0;
    else if (out_xfer && err_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      err_q       <= err_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = code_q;
  assign out_err   = err_q;
  assign out_last  = last_q;
  assign err_cnt   = cnt_q;

endmodule

// File: doc/encoder_nx_stream.md
Name: encoder_nx_stream

Overview:
Parametrised N-input to log2(N)-bit encoder. It extends the fixed 4-to-2 one-hot encoder with a registered output and a valid/ready handshake on both sides. It also adds three selectable modes: strict one-hot, priority, and scan. Scan mode serialises every set bit into one code beat each. The block sits between request/status vectors and downstream consumers that need an index, an error flag and an error count.

Parameters:
N, 8, number of input lines; power of two, at least 2.
W, $clog2(N), output code width; derived, not overridden.
MODE, 0, 0=STRICT one-hot, 1=PRIO priority, 2=SCAN serialise all set bits.
PRIO_MSB, 0, 1 = highest index first/wins; 0 = lowest index first/wins.
CNT_W, 8, error counter width.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  N  input vector
out_valid  out  1  out_code/out_err/out_last valid
out_ready  in  1  consumer accepts beat
out_code  out  W  encoded index
out_err  out  1  beat is an error beat (see Behaviour)
out_last  out  1  final beat for the accepted vector
err_clr  in  1  clears err_cnt
err_cnt  out  CNT_W  saturating count of transferred error beats

Behaviour:
- Reset (rst high at clk edge): out_valid=0, out_code=0, out_err=0, out_last=0, err_cnt=0, pending=0, state IDLE. in_ready=0 while rst is high.
- Handshake:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready), combinational.
  - While out_valid & !out_ready, out_code/out_err/out_last are held stable.
  - out_valid drops only after a transfer with no new beat loaded.
- Latency: registered output; beat appears the cycle after input transfer. Full throughput of 1 vector/cycle in STRICT/PRIO.
- STRICT: exactly one bit set -> code=index, err=0. Zero or multiple bits -> code=0, err=1. last=1 always.
- PRIO: code = highest (PRIO_MSB=1) or lowest set index. Zero vector -> code=0, err=1. last=1 always.
- SCAN:
  - Zero vector -> single beat code=0, err=1, last=1.
  - Otherwise the first index (per PRIO_MSB) loads into the output register, and pending = vector with that bit cleared.
  - last = (pending==0).
  - pending!=0 -> state SCAN.
- SCAN state:
  - On each output transfer, load the next index from pending, clear that bit, and set last when pending becomes 0.
  - Go to IDLE in the same cycle the final beat loads; the final beat is still held in the output register.
  - This lets a new vector be accepted in the cycle the final beat transfers (no bubble).
- States: IDLE, SCAN only. STRICT/PRIO never leave IDLE.
- err_cnt:
  - +1 on each output transfer with out_err=1.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority: if clear and increment coincide, result is 0.
- Reset mid-SCAN: the pending beats are discarded, with no partial output after reset.
- Inputs are never X-propagated to the output; every undefined case yields code=0, err=1.

Decomposition:
- Package enc_pkg:
  - mode constants ENC_STRICT=0, ENC_PRIO=1, ENC_SCAN=2
  - state enum IDLE/SCAN
  - helper localparam for saturating max
- One combinational sub-module, priority_pick (params N, PRIO_MSB). Inputs: vector. Outputs: index, any, onehot. Used for both the input vector and the pending register.

Test Plan:
1. N=8, MODE=0: in_data=8'b0001_0000, out_ready=1 -> next cycle out_code=4, err=0, last=1, err_cnt=0.
2. MODE=0: in_data=8'b0001_0100 -> out_code=0, err=1, err_cnt=1. Then in_data=0 -> err=1, err_cnt=2.
3. MODE=1: in_data=8'b0010_0110 -> PRIO_MSB=1 gives code=5; PRIO_MSB=0 gives code=1. Back-to-back vectors give one beat per cycle.
4. MODE=2, PRIO_MSB=0: in_data=8'b1000_0101, out_ready=1 -> beats code 0,2,7 on consecutive cycles, last only on 7. in_ready low for 2 cycles; next vector is accepted in the cycle code 7 transfers.
5. MODE=2: out_ready=0 for 3 cycles mid-scan -> code held, in_ready=0. Then rst pulse -> next cycle out_valid=0, err_cnt=0, in_ready=1 after rst deasserts.
6. CNT_W=2: 5 error beats -> err_cnt=3 (saturated). err_clr asserted with a simultaneous error transfer -> err_cnt=0.
